// File: rtl/npc_exec_core.sv
// Execute-side core: 32-entry register file, single-op adder ALU and 3-to-8 decoder.
// Register state clears asynchronously; the ALU and decoder are pure combinational logic.
module npc_exec_core #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    output logic [DATA_WIDTH-1:0] rdata1,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic [DATA_WIDTH-1:0] rdata2,
    input  logic [DATA_WIDTH-1:0] alu_src1,
    input  logic [DATA_WIDTH-1:0] alu_src2,
    input  logic                  alu_op,
    output logic [DATA_WIDTH-1:0] alu_result,
    input  logic [2:0]            dec_in,
    output logic [7:0]            dec_out
);

    localparam int NREG = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NREG];
    logic                  wr_en_d;

    assign wr_en_d = wen && (waddr != '0);

    // Entry 0 is only ever cleared, so it reads as zero without a read-side mux.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en_d) begin
            regs_q[waddr] <= wdata;
        end
    end

    assign rdata1 = regs_q[raddr1];
    assign rdata2 = regs_q[raddr2];

    assign alu_result = alu_op ? (alu_src1 + alu_src2) : '0;

    assign dec_out = 8'd1 << dec_in;

endmodule

// File: tb/tb_npc_exec_core.sv
// Testbench for npc_exec_core: directed vectors, reset corner cases
// and a random register/ALU/decoder run against a reference model.
module tb_npc_exec_core;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wen = 1'b0;
    logic [AW-1:0] waddr = '0;
    logic [DW-1:0] wdata = '0;
    logic [AW-1:0] raddr1 = '0;
    logic [AW-1:0] raddr2 = '0;
    logic [DW-1:0] rdata1;
    logic [DW-1:0] rdata2;
    logic [DW-1:0] alu_src1 = '0;
    logic [DW-1:0] alu_src2 = '0;
    logic          alu_op = 1'b0;
    logic [DW-1:0] alu_result;
    logic [2:0]    dec_in = '0;
    logic [7:0]    dec_out;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] model [32];

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  d;
        logic [31:0] exp_r;
        logic [7:0]  exp_d;
    } vec_t;

    vec_t vecs [8];

    npc_exec_core #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .wen        (wen),
        .waddr      (waddr),
        .wdata      (wdata),
        .raddr1     (raddr1),
        .rdata1     (rdata1),
        .raddr2     (raddr2),
        .rdata2     (rdata2),
        .alu_src1   (alu_src1),
        .alu_src2   (alu_src2),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .dec_in     (dec_in),
        .dec_out    (dec_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    initial begin
        logic [31:0] sum;
        logic [7:0]  dexp;

        vecs[0] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0002, 3'd0, 32'h0000_0001, 8'h01};
        vecs[1] = '{1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 3'd1, 32'hFFFF_FFFF, 8'h02};
        vecs[2] = '{1'b0, 32'h1234_5678, 32'h0000_0001, 3'd2, 32'h0000_0000, 8'h04};
        vecs[3] = '{1'b1, 32'h0000_0000, 32'h0000_0000, 3'd3, 32'h0000_0000, 8'h08};
        vecs[4] = '{1'b1, 32'h0000_0001, 32'h0000_0001, 3'd4, 32'h0000_0002, 8'h10};
        vecs[5] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd5, 32'h0000_0000, 8'h20};
        vecs[6] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd6, 32'hFFFF_FFFE, 8'h40};
        vecs[7] = '{1'b1, 32'h1234_5678, 32'h1111_1111, 3'd7, 32'h2345_6789, 8'h80};

        // Reset pulse, then read every register through both ports.
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 1; i < 32; i++) begin
            raddr1 = AW'(i);
            raddr2 = AW'(31 - i + 1);
            #1;
            check($sformatf("reset_rd1_x%0d", i), rdata1, 32'h0);
            check($sformatf("reset_rd2_x%0d", 32 - i), rdata2, 32'h0);
        end

        // Combinational ALU and decoder vectors.
        for (int i = 0; i < 8; i++) begin
            alu_op   = vecs[i].op;
            alu_src1 = vecs[i].a;
            alu_src2 = vecs[i].b;
            dec_in   = vecs[i].d;
            #1;
            check($sformatf("vec%0d_alu", i), alu_result, vecs[i].exp_r);
            check($sformatf("vec%0d_dec", i), {24'h0, dec_out}, {24'h0, vecs[i].exp_d});
        end

        // Write x5: old value before the edge, new value after, on both ports.
        @(negedge clk);
        wen = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF;
        raddr1 = 5'd5; raddr2 = 5'd5;
        #1;
        check("x5_before_rd1", rdata1, 32'h0);
        check("x5_before_rd2", rdata2, 32'h0);
        @(posedge clk);
        #1;
        check("x5_after_rd1", rdata1, 32'hDEAD_BEEF);
        check("x5_after_rd2", rdata2, 32'hDEAD_BEEF);

        // Writes to x0 are ignored.
        @(negedge clk);
        waddr = 5'd0; wdata = 32'h1234_5678; raddr1 = 5'd0;
        @(posedge clk);
        #1;
        check("x0_write_ignored", rdata1, 32'h0);

        // wen low leaves x7 unchanged.
        @(negedge clk);
        waddr = 5'd7; wdata = 32'h0000_1111;
        @(posedge clk);
        @(negedge clk);
        wen = 1'b0; wdata = 32'hFFFF_FFFF; raddr1 = 5'd7;
        @(posedge clk);
        #1;
        check("x7_wen_low", rdata1, 32'h0000_1111);

        // Mid-run asynchronous reset clears x3 before any edge.
        @(negedge clk);
        wen = 1'b1; waddr = 5'd3; wdata = 32'hA5A5_A5A5; raddr1 = 5'd3;
        @(posedge clk);
        #1;
        check("x3_written", rdata1, 32'hA5A5_A5A5);
        @(negedge clk);
        wen = 1'b1; waddr = 5'd9; wdata = 32'h5555_AAAA; raddr2 = 5'd9;
        #2;
        reset = 1'b0;
        alu_op = 1'b1; alu_src1 = 32'd3; alu_src2 = 32'd4; dec_in = 3'd5;
        #1;
        check("x3_async_clear", rdata1, 32'h0);
        check("alu_in_reset", alu_result, 32'd7);
        check("dec_in_reset", {24'h0, dec_out}, 32'h20);
        @(posedge clk);
        #1;
        check("x9_blocked_in_reset", rdata2, 32'h0);
        check("x5_cleared", dut.rdata1 == 32'h0 ? 32'h0 : rdata1, 32'h0);

        // Release between edges: the write lands on the very next edge.
        @(negedge clk);
        reset = 1'b1;
        wen = 1'b1; waddr = 5'd4; wdata = 32'hCAFE_F00D; raddr1 = 5'd4;
        #1;
        check("x4_before_first_edge", rdata1, 32'h0);
        @(posedge clk);
        #1;
        check("x4_first_edge_write", rdata1, 32'hCAFE_F00D);
        check("x9_still_zero", rdata2, 32'h0);

        // Random phase against the array model, starting from a fresh reset.
        @(negedge clk);
        wen = 1'b0;
        reset = 1'b0;
        #2;
        reset = 1'b1;
        for (int i = 0; i < 32; i++) model[i] = '0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            wen      = ($urandom_range(0, 3) != 0);
            waddr    = AW'($urandom_range(0, 31));
            wdata    = $urandom;
            raddr1   = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, 31));
            raddr2   = ($urandom_range(0, 3) == 0) ? raddr1 : AW'($urandom_range(0, 31));
            alu_op   = 1'($urandom_range(0, 1));
            alu_src1 = $urandom;
            alu_src2 = ($urandom_range(0, 7) == 0) ? ~alu_src1 + 32'd1 : $urandom;
            dec_in   = 3'($urandom_range(0, 7));
            #1;
            sum = alu_src1 + alu_src2;
            dexp = '0;
            for (int b = 0; b < 8; b++) dexp[b] = (int'(dec_in) == b);
            check("rnd_rd1", rdata1, model[raddr1]);
            check("rnd_rd2", rdata2, model[raddr2]);
            check("rnd_alu", alu_result, alu_op ? sum : 32'h0);
            check("rnd_dec", {24'h0, dec_out}, {24'h0, dexp});
            @(posedge clk);
            if (wen && waddr != 0) model[waddr] = wdata;
            #1;
            check("rnd_post_rd1", rdata1, model[raddr1]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
